// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers with bounded bursts.
// Optional macro FIFO_ARB_XFER_CNT_EN adds the xfer_count output (16-bit transfer counter).
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_we,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           owner
`ifdef FIFO_ARB_XFER_CNT_EN
  ,
  output logic [15:0]                   xfer_count
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_r;
  logic [ID_WIDTH-1:0]   rr_ptr_r;
  logic [ID_WIDTH-1:0]   owner_r;
  logic [3:0]            burst_cnt_r;
  logic                  busy_r;
  logic [ID_WIDTH-1:0]   pick_s;
  logic [ID_WIDTH-1:0]   next_ptr_s;
  logic                  found_s;
  logic                  sel_req_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [NUM_REQ-1:0]    gnt_s;
  logic                  xfer_s;
  logic                  last_s;

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int sum;
    int idx;
    sum     = 0;
    idx     = 0;
    pick_s  = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr_r) + k;
      idx = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
      if (!found_s && req[idx]) begin
        pick_s  = ID_WIDTH'(idx);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Owner's request/data select and per-requester transfer strobes
  always_comb begin
    sel_req_s  = 1'b0;
    sel_data_s = '0;
    gnt_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_req_s  = sel_req_s | ((owner_r == ID_WIDTH'(i)) & req[i]);
      sel_data_s = sel_data_s |
                   ({DATA_WIDTH{owner_r == ID_WIDTH'(i)}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
      gnt_s[i]   = (state_r == BURST) & ~rst & ~fifo_full & req[i] & (owner_r == ID_WIDTH'(i));
    end
  end

  assign xfer_s     = |gnt_s;
  assign last_s     = (burst_cnt_r == 4'(MAX_BURST - 1));
  assign next_ptr_s = (owner_r == ID_WIDTH'(NUM_REQ - 1)) ? '0 : (owner_r + ID_WIDTH'(1));

  assign gnt       = gnt_s;
  assign fifo_we   = xfer_s;
  assign fifo_data = xfer_s ? sel_data_s : '0;
  assign busy      = busy_r & ~rst;
  assign owner     = owner_r;

  // Arbitration FSM: IDLE picks an owner, BURST streams until limit or request drop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      burst_cnt_r <= 4'd0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s && !fifo_full) begin
            owner_r     <= pick_s;
            burst_cnt_r <= 4'd0;
            state_r     <= BURST;
            busy_r      <= 1'b1;
          end
        end
        BURST: begin
          if ((xfer_s && last_s) || !sel_req_s) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            rr_ptr_r    <= next_ptr_s;
            burst_cnt_r <= 4'd0;
          end else if (xfer_s) begin
            burst_cnt_r <= burst_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_XFER_CNT_EN
  logic [15:0] xfer_count_r;

  // Free-running count of accepted words, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_r <= 16'd0;
    end else if (xfer_s) begin
      xfer_count_r <= xfer_count_r + 16'd1;
    end
  end

  assign xfer_count = xfer_count_r;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (default parameters).
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;
  logic [3:0]  gnt;
  logic        fifo_we;
  logic [7:0]  fifo_data;
  logic        busy;
  logic [1:0]  owner;
`ifdef FIFO_ARB_XFER_CNT_EN
  logic [15:0] xfer_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  fifo_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .fifo_full (fifo_full),
    .gnt       (gnt),
    .fifo_we   (fifo_we),
    .fifo_data (fifo_data),
    .busy      (busy),
    .owner     (owner)
`ifdef FIFO_ARB_XFER_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check the combinational/registered outputs, then advance.
  task automatic vec(input string tag, input logic r_rst, input logic [3:0] r, input logic f,
                     input logic [31:0] d, input logic [3:0] eg, input logic [7:0] ed,
                     input logic eb, input logic [1:0] eo);
    rst       = r_rst;
    req       = r;
    fifo_full = f;
    req_data  = d;
    #2;
    check({tag, ".gnt"},  32'(gnt),       32'(eg));
    check({tag, ".we"},   32'(fifo_we),   32'(|eg));
    check({tag, ".data"}, 32'(fifo_data), 32'(ed));
    check({tag, ".busy"}, 32'(busy),      32'(eb));
    if (eb) check({tag, ".owner"}, 32'(owner), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] RR_DATA = 32'hD3D2D1D0;

  initial begin
    int ows [5];
    logic [1:0] o;
    ows = '{0, 1, 2, 3, 0};
    rst = 1'b1; req = 4'b0000; fifo_full = 1'b0; req_data = 32'h0;
    @(posedge clk);
    #1;

    // Reset: outputs forced low even with all requests high
    vec("rst0", 1'b1, 4'b1111, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);
    vec("rst1", 1'b1, 4'b1111, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);

    // Single requester: bubble, 4-word burst A0..A3, gap, A4..A5, drop
    vec("t1.arb", 1'b0, 4'b0001, 1'b0, 32'h000000A0, 4'b0000, 8'h00, 1'b0, 2'd0);
    for (int n = 0; n < 4; n++)
      vec("t1.b0", 1'b0, 4'b0001, 1'b0, 32'(8'hA0 + 8'(n)), 4'b0001, 8'hA0 + 8'(n), 1'b1, 2'd0);
    vec("t1.gap", 1'b0, 4'b0001, 1'b0, 32'h000000A4, 4'b0000, 8'h00, 1'b0, 2'd0);
    vec("t1.b1a", 1'b0, 4'b0001, 1'b0, 32'h000000A4, 4'b0001, 8'hA4, 1'b1, 2'd0);
    vec("t1.b1b", 1'b0, 4'b0001, 1'b0, 32'h000000A5, 4'b0001, 8'hA5, 1'b1, 2'd0);
    vec("t1.drop", 1'b0, 4'b0000, 1'b0, 32'h0, 4'b0000, 8'h00, 1'b1, 2'd0);
    vec("t1.idle", 1'b0, 4'b0000, 1'b0, 32'h0, 4'b0000, 8'h00, 1'b0, 2'd0);

    // Round robin from a fresh reset: owners 0,1,2,3,0
    vec("rst2", 1'b1, 4'b0000, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);
    for (int b = 0; b < 5; b++) begin
      o = 2'(ows[b]);
      vec("t2.gap", 1'b0, 4'b1111, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);
      for (int k = 0; k < 4; k++)
        vec("t2.xfer", 1'b0, 4'b1111, 1'b0, RR_DATA, 4'(4'b0001 << o), 8'hD0 + 8'(o), 1'b1, o);
    end
`ifdef FIFO_ARB_XFER_CNT_EN
    check("cnt20", 32'(xfer_count), 32'd20);
`endif

    // Full stall: owner 1 after 2 transfers, full for 3 cycles, then 2 more
    vec("t3.arb", 1'b0, 4'b0010, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);
    vec("t3.x0", 1'b0, 4'b0010, 1'b0, RR_DATA, 4'b0010, 8'hD1, 1'b1, 2'd1);
    vec("t3.x1", 1'b0, 4'b0010, 1'b0, RR_DATA, 4'b0010, 8'hD1, 1'b1, 2'd1);
    for (int s = 0; s < 3; s++)
      vec("t3.stall", 1'b0, 4'b0010, 1'b1, RR_DATA, 4'b0000, 8'h00, 1'b1, 2'd1);
    vec("t3.x2", 1'b0, 4'b0010, 1'b0, RR_DATA, 4'b0010, 8'hD1, 1'b1, 2'd1);
    vec("t3.x3", 1'b0, 4'b0010, 1'b0, RR_DATA, 4'b0010, 8'hD1, 1'b1, 2'd1);
    vec("t3.fullidle", 1'b0, 4'b0010, 1'b1, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);
    vec("t3.idle", 1'b0, 4'b0000, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);

    // Early drop by requester 2, then requester 3, reset during its 2nd transfer
    vec("t4.arb", 1'b0, 4'b1100, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);
    vec("t4.x0", 1'b0, 4'b1100, 1'b0, RR_DATA, 4'b0100, 8'hD2, 1'b1, 2'd2);
    vec("t4.x1", 1'b0, 4'b1100, 1'b0, RR_DATA, 4'b0100, 8'hD2, 1'b1, 2'd2);
    vec("t4.drop", 1'b0, 4'b1000, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b1, 2'd2);
    vec("t4.gap", 1'b0, 4'b1000, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);
    vec("t4.x3a", 1'b0, 4'b1000, 1'b0, RR_DATA, 4'b1000, 8'hD3, 1'b1, 2'd3);
    vec("t5.rst", 1'b1, 4'b1000, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);
    vec("t5.arb", 1'b0, 4'b1000, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);
    vec("t5.x0", 1'b0, 4'b1000, 1'b0, RR_DATA, 4'b1000, 8'hD3, 1'b1, 2'd3);
    vec("t5.drop", 1'b0, 4'b0000, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b1, 2'd3);
    vec("t5.idle", 1'b0, 4'b0000, 1'b0, RR_DATA, 4'b0000, 8'h00, 1'b0, 2'd0);
`ifdef FIFO_ARB_XFER_CNT_EN
    check("cnt_after_rst", 32'(xfer_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
